// File: rtl/mul_acc.sv
// Multiply-accumulate stage: one 8x8 product per accepted pair, summed over a
// burst of N_TERMS pairs. Define MUL_ACC_SATURATE_EN to clamp the sum instead of wrapping.

module mul (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);
   assign p = {8'd0, a} * {8'd0, b};
endmodule

module mul_acc #(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);
   // Handshake: a transfer happens on a rising edge where valid && ready; ready
   // never depends on valid, and valid/data hold until that edge.

   localparam int CNT_W = $clog2(N_TERMS + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [15:0]      product;
   logic [15:0]      p_reg;
   logic             p_vld;
   logic             accept;
   logic             clear;
   logic [ACC_W-1:0] sum_nxt;

   mul u_mul (
      .a (a),
      .b (b),
      .p (product)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      clear     = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               clear     = 1'b1;
               state_nxt = S_ACC;
            end
         end
         S_ACC: begin
            in_ready = (cnt < LAST);
            // A pending product with all pairs counted is the final term.
            if (p_vld && (cnt == LAST)) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;

`ifdef MUL_ACC_SATURATE_EN
   logic [ACC_W:0] sum_wide;

   always_comb begin
      sum_wide = {1'b0, sum} + (ACC_W+1)'(p_reg);
      sum_nxt  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
   end
`else
   assign sum_nxt = sum + ACC_W'(p_reg);
`endif

   // Product register and accumulator overlap so a pair per cycle is sustained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         p_reg <= '0;
         p_vld <= 1'b0;
         sum   <= '0;
      end else if (clear) begin
         cnt   <= '0;
         p_vld <= 1'b0;
         sum   <= '0;
      end else begin
         if (accept) begin
            p_reg <= product;
            cnt   <= cnt + CNT_W'(1);
         end
         if (p_vld) begin
            sum <= sum_nxt;
         end
         p_vld <= accept;
      end
   end

endmodule
